mem_arbiter: RTL and testbench

Two-master arbiter feeding the single-port word memory (`mem_mod`) from the core's instruction and data interfaces. Accepts OBI-style req/gnt/rvalid transactions on both masters and selects one per cycle with round-robin priority. Converts byte addresses to word indices and merges byte-enabled writes into full-word writes. Captures read data at grant and returns it to the owning master on the following cycle.

---
 rtl/mem_arbiter.sv | 102 ++++++++++
 tb/tb_mem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the instruction (m0) and data (m1) masters in front of the single-port
// word memory. Merges byte-enabled writes into full-word writes and responds one cycle after grant.
module mem_arbiter #(
  parameter int MEM_WORDS  = 256,
  parameter int ADDR_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,

  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,

  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic {M0 = 1'b0, M1 = 1'b1} master_e;

  master_e     prio_q;
  master_e     owner_q;
  master_e     sel;
  logic        pend_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] sel_addr;
  logic [31:0] word_idx;
  logic        in_range;
  logic        grant;
  logic        sel_write;
  logic        rsp;

  always_comb begin
    sel = M0;
    if (m0_req_i && m1_req_i) sel = prio_q;
    else if (m1_req_i)        sel = M1;
  end

  assign mem_req_o = m0_req_i | m1_req_i;
  assign sel_addr  = (sel == M1) ? m1_addr_i : m0_addr_i;
  assign word_idx  = sel_addr >> ADDR_SHIFT;
  assign in_range  = word_idx < 32'(MEM_WORDS);
  assign grant     = mem_gnt_i & mem_req_o;
  assign sel_write = (sel == M1) & m1_we_i;

  assign m0_gnt_o   = grant & (sel == M0);
  assign m1_gnt_o   = grant & (sel == M1);
  assign mem_addr_o = word_idx;
  assign mem_we_o   = grant & sel_write & in_range;

  // Read-modify-write: disabled byte lanes are refilled from the word currently addressed.
  always_comb begin
    mem_wdata_o = mem_rdata_i;
    for (int n = 0; n < 4; n++) begin
      if (m1_be_i[n]) mem_wdata_o[8*n +: 8] = m1_wdata_i[8*n +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q  <= M0;
      owner_q <= M0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      pend_q <= grant;
      if (grant) begin
        prio_q  <= (sel == M0) ? M1 : M0;
        owner_q <= sel;
        err_q   <= (sel == M1) && !in_range;
        rdata_q <= (in_range && !sel_write) ? mem_rdata_i : '0;
      end
    end
  end

  // pend_q filters stray memory responses and those belonging to a grant lost to reset.
  assign rsp         = mem_rvalid_i & pend_q;
  assign m0_rvalid_o = rsp & (owner_q == M0);
  assign m1_rvalid_o = rsp & (owner_q == M1);
  assign m0_rdata_o  = m0_rvalid_o ? rdata_q : '0;
  assign m1_rdata_o  = m1_rvalid_o ? rdata_q : '0;
  assign m1_err_o    = m1_rvalid_o & err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a word-memory model, a transaction-level reference model that
// queues expected responses at grant, and an independent monitor that checks every master response.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req_i = 1'b0;
  logic [31:0] m0_addr_i = '0;
  logic        m0_gnt_o, m0_rvalid_o;
  logic [31:0] m0_rdata_o;
  logic        m1_req_i = 1'b0;
  logic [31:0] m1_addr_i = '0;
  logic        m1_we_i = 1'b0;
  logic [3:0]  m1_be_i = '0;
  logic [31:0] m1_wdata_i = '0;
  logic        m1_gnt_o, m1_rvalid_o, m1_err_o;
  logic [31:0] m1_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_WORDS(256), .ADDR_SHIFT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
    .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
    .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory device: combinational read, write on the clock edge, response one cycle after grant.
  logic [31:0] dev_mem [256];
  logic        rv_q = 1'b0;
  logic        spur = 1'b0;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clk) begin
    rv_q <= mem_req_o & mem_gnt_i;
    if (pl_en) dev_mem[pl_idx] <= pl_data;
    else if (mem_we_o && mem_addr_o < 32'd256) dev_mem[mem_addr_o[7:0]] <= mem_wdata_o;
  end

  assign mem_rvalid_i = rv_q | spur;
  assign mem_rdata_i  = (mem_addr_o < 32'd256) ? dev_mem[mem_addr_o[7:0]] : 32'hDEAD_BEEF;

  // Reference model: transaction-level view of arbitration, memory contents and responses.
  typedef struct {
    int          cyc;
    logic        m;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] ref_mem [256];
  logic        mprio = 1'b0;

  always @(negedge clk) begin : model
    logic        win, gr;
    logic [31:0] a, idx;
    rsp_t        r;
    #1;
    if (pl_en) ref_mem[pl_idx] = pl_data;
    if (!rst_n) begin
      exp_q.delete();
      mprio = 1'b0;
    end else begin
      if (m0_req_i && m1_req_i) win = mprio;
      else                      win = m1_req_i;
      gr  = (m0_req_i || m1_req_i) && mem_gnt_i;
      a   = win ? m1_addr_i : m0_addr_i;
      idx = a / 4;
      chk1("m0_gnt", m0_gnt_o, gr && !win);
      chk1("m1_gnt", m1_gnt_o, gr && win);
      chk1("mem_we", mem_we_o, gr && win && m1_we_i && (idx < 32'd256));
      if (m0_req_i || m1_req_i) chk("mem_addr", mem_addr_o, idx);
      if (gr) begin
        r.cyc = cyc;
        r.m   = win;
        r.err = win && (idx >= 32'd256);
        if (win && m1_we_i) begin
          r.rdata = '0;
          if (idx < 32'd256)
            for (int b = 0; b < 4; b++)
              if (m1_be_i[b]) ref_mem[idx[7:0]][8*b +: 8] = m1_wdata_i[8*b +: 8];
        end else begin
          r.rdata = (idx < 32'd256) ? ref_mem[idx[7:0]] : 32'h0;
        end
        exp_q.push_back(r);
        mprio = !win;
      end
    end
  end

  // Monitor: pops the oldest expected response whenever a master sees rvalid.
  always @(negedge clk) begin : monitor
    rsp_t        r;
    logic        act_m;
    if (rst_n) begin
      if (!m0_rvalid_o) chk("m0_rdata_idle", m0_rdata_o, 32'h0);
      if (!m1_rvalid_o) begin
        chk("m1_rdata_idle", m1_rdata_o, 32'h0);
        chk1("m1_err_idle", m1_err_o, 1'b0);
      end
      if (m0_rvalid_o && m1_rvalid_o) begin
        flag("rvalid on both masters");
      end else if (m0_rvalid_o || m1_rvalid_o) begin
        if (exp_q.size() == 0) begin
          flag("rvalid with no outstanding grant");
        end else begin
          r     = exp_q.pop_front();
          act_m = m1_rvalid_o;
          chk1("rsp_owner", act_m, r.m);
          chk("rsp_latency", cyc, r.cyc + 1);
          chk("rsp_rdata", act_m ? m1_rdata_o : m0_rdata_o, r.rdata);
          if (act_m) chk1("rsp_err", m1_err_o, r.err);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc - 1) begin
        flag("missing rvalid");
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] idx;
    case ($urandom_range(0, 9))
      0:       idx = $urandom_range(256, 400);
      1, 2:    idx = $urandom_range(0, 255);
      default: idx = $urandom_range(0, 15);
    endcase
    return (idx << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin : stim
    logic g0, g1;
    #2;
    chk1("reset_m0_gnt", m0_gnt_o, 1'b0);
    chk1("reset_m1_gnt", m1_gnt_o, 1'b0);
    chk1("reset_m0_rvalid", m0_rvalid_o, 1'b0);
    chk1("reset_m1_rvalid", m1_rvalid_o, 1'b0);
    chk1("reset_m1_err", m1_err_o, 1'b0);
    chk("reset_m0_rdata", m0_rdata_o, 32'h0);
    chk("reset_m1_rdata", m1_rdata_o, 32'h0);
    chk1("reset_mem_we", mem_we_o, 1'b0);

    for (int i = 0; i < 256; i++) begin
      step();
      pl_en   = 1'b1;
      pl_idx  = 8'(i);
      pl_data = (i == 0) ? 32'h1122_3344 : (i == 4) ? 32'h0000_0037 : $urandom;
    end
    step();
    pl_en     = 1'b0;
    rst_n     = 1'b1;
    mem_gnt_i = 1'b1;

    // Contention straight after reset: m0 first, then alternate.
    step();
    m0_req_i = 1'b1; m0_addr_i = 32'h0;
    m1_req_i = 1'b1; m1_addr_i = 32'h10; m1_we_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk1("contention_m0_gnt", m0_gnt_o, (k % 2) == 0);
      chk1("contention_m1_gnt", m1_gnt_o, (k % 2) == 1);
      if (k > 0) chk1("contention_m0_rvalid", m0_rvalid_o, (k % 2) == 1);
      step();
    end
    m0_req_i = 1'b0; m1_req_i = 1'b0;

    step();
    m0_req_i = 1'b1; m0_addr_i = 32'h10;
    settle(); chk1("single_read_gnt", m0_gnt_o, 1'b1);
    step();
    m0_req_i = 1'b0;
    settle();
    chk1("single_read_rvalid", m0_rvalid_o, 1'b1);
    chk("single_read_rdata", m0_rdata_o, 32'h37);

    step();
    m1_req_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = 32'h0; m1_be_i = 4'b0010; m1_wdata_i = 32'hAABB_CCDD;
    settle(); chk1("byte_write_we", mem_we_o, 1'b1);
    step();
    m1_req_i = 1'b0;
    settle();
    chk("byte_write_word", dev_mem[0], 32'h1122_CC44);
    chk1("byte_write_rvalid", m1_rvalid_o, 1'b1);
    chk("byte_write_rdata", m1_rdata_o, 32'h0);
    chk1("byte_write_err", m1_err_o, 1'b0);

    step();
    m1_req_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = 32'h4; m1_be_i = 4'b0000; m1_wdata_i = 32'hFFFF_FFFF;
    step();
    m1_req_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = 32'h400; m1_be_i = 4'hF;
    settle(); chk1("oor_write_we", mem_we_o, 1'b0);
    step();
    m1_req_i = 1'b0;
    settle();
    chk1("oor_write_rvalid", m1_rvalid_o, 1'b1);
    chk1("oor_write_err", m1_err_o, 1'b1);
    chk("oor_write_rdata", m1_rdata_o, 32'h0);

    step();
    m0_req_i = 1'b1; m0_addr_i = 32'h400;
    step();
    m0_req_i = 1'b0;
    settle(); chk("oor_m0_rdata", m0_rdata_o, 32'h0);

    // Back-to-back: m1 read then m0 read with no idle cycle between them.
    step();
    m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 32'h10;
    step();
    m1_req_i = 1'b0; m0_req_i = 1'b1; m0_addr_i = 32'h0;
    settle();
    chk1("b2b_m0_gnt", m0_gnt_o, 1'b1);
    chk1("b2b_m1_rvalid", m1_rvalid_o, 1'b1);
    chk("b2b_m1_rdata", m1_rdata_o, 32'h37);
    step();
    m0_req_i = 1'b0;
    settle();
    chk1("b2b_m0_rvalid", m0_rvalid_o, 1'b1);
    chk("b2b_m0_rdata", m0_rdata_o, 32'h1122_CC44);

    step();
    spur = 1'b1;
    settle();
    chk1("stray_m0_rvalid", m0_rvalid_o, 1'b0);
    chk1("stray_m1_rvalid", m1_rvalid_o, 1'b0);

    // Reset in a grant cycle while priority points at m1.
    step();
    spur = 1'b0;
    m0_req_i = 1'b1; m0_addr_i = 32'h10;
    m1_req_i = 1'b1; m1_addr_i = 32'h0; m1_we_i = 1'b0;
    #1 rst_n = 1'b0;
    step();
    rst_n = 1'b1; m0_req_i = 1'b0; m1_req_i = 1'b0;
    settle();
    chk1("rst_drop_m0_rvalid", m0_rvalid_o, 1'b0);
    chk1("rst_drop_m1_rvalid", m1_rvalid_o, 1'b0);
    step();
    m0_req_i = 1'b1; m1_req_i = 1'b1;
    settle(); chk1("rst_prio_m0", m0_gnt_o, 1'b1);
    step();
    m0_req_i = 1'b0; m1_req_i = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      g0 = m0_gnt_o;
      g1 = m1_gnt_o;
      @(posedge clk);
      #1;
      if (!m0_req_i || g0) begin
        m0_req_i  = ($urandom_range(0, 2) != 0);
        m0_addr_i = rand_addr();
      end
      if (!m1_req_i || g1) begin
        m1_req_i   = ($urandom_range(0, 2) != 0);
        m1_addr_i  = rand_addr();
        m1_we_i    = ($urandom_range(0, 1) != 0);
        m1_be_i    = 4'($urandom);
        m1_wdata_i = $urandom;
      end
      mem_gnt_i = ($urandom_range(0, 3) != 0);
    end

    step();
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    repeat (3) step();
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    for (int i = 0; i < 256; i++) chk($sformatf("mem_word_%0d", i), dev_mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
